posit_field_extract: RTL and testbench

Pipelined posit field extractor sitting directly downstream of the leading-digit detector in the posit decoder. It takes the sign-corrected posit body together with the detector's one-hot run-end vector and all-ones / all-zeros flags. It produces the regime value k, exponent, left-aligned fraction, combined scale and zero/NaR flags. It uses a 2-stage valid/ready pipeline with full throughput and backpressure.

---
 rtl/posit_field_extract_pkg.sv | 39 +++
 rtl/ldd_onehot_enc.sv | 18 +
 rtl/posit_field_extract.sv | 125 ++++++++++++
 tb/tb_posit_field_extract.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_field_extract_pkg.sv
// Shared widths and record types for the posit decoder field-extract pipeline.
// Widths are fixed here for the 8-bit, es=1 posit configuration.
package posit_dec_pkg;

    localparam int N  = 8;
    localparam int ES = 1;
    localparam int KW = $clog2(N) + 1;
    localparam int FW = N - 3 - ES;
    localparam int BW = N - 1;
    localparam int OW = N - 2;
    localparam int JW = $clog2(OW);

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          nar;
        logic [KW-1:0] k;
        logic [ES-1:0] exp;
        logic [FW-1:0] frac;
        logic [KW+ES-1:0] scale;
    } posit_res_t;

    typedef struct packed {
        logic          sign;
        logic          allone;
        logic          allzero;
        logic [BW-1:0] body;
        logic [JW-1:0] j;
        logic [KW-1:0] k;
    } s1_rec_t;

    // Run length is measured from the body MSB down to the terminator at bit j.
    function automatic logic [KW-1:0] regime_k(input logic lead, input logic [JW-1:0] j);
        logic [KW-1:0] m;
        m = KW'(N - 2) - KW'(j);
        return lead ? (m - KW'(1)) : (KW'(0) - m);
    endfunction

endpackage

// File: rtl/ldd_onehot_enc.sv
// Priority one-hot to binary encoder; the highest set bit wins so a
// malformed multi-hot vector still yields a deterministic index.
module ldd_onehot_enc #(
    parameter int W  = 6,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/posit_field_extract.sv
// Two-stage valid/ready posit field extractor fed by the leading-digit detector.
// Optional one-hot sanity checker enabled by defining POSIT_ONEHOT_CHECK_EN.
module posit_field_extract
    import posit_dec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [BW-1:0]        in_body,
    input  logic [OW-1:0]        in_onehot,
    input  logic                 in_allone,
    input  logic                 in_allzero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_nar,
    output logic signed [KW-1:0] out_k,
    output logic [ES-1:0]        out_exp,
    output logic [FW-1:0]        out_frac,
    output logic signed [KW+ES-1:0] out_scale,
    output logic                 out_err
);

    logic       s1_valid, s2_valid;
    logic       s1_advance, s2_advance;
    logic [JW-1:0] enc_idx;
    s1_rec_t    s1_d, s1_q;
    posit_res_t res_d, res_q;
    logic [JW-1:0] shamt;
    logic [BW-1:0] shifted;

    assign s2_advance = !s2_valid | out_ready;
    assign s1_advance = !s1_valid | s2_advance;
    assign in_ready   = !rst & (!s1_valid | s1_advance);

    ldd_onehot_enc #(.W(OW), .IW(JW)) u_enc (
        .onehot (in_onehot),
        .idx    (enc_idx)
    );

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = in_sign;
        s1_d.allone  = in_allone;
        s1_d.allzero = in_allzero;
        s1_d.body    = in_body;
        s1_d.j       = enc_idx;
        if (in_allone)       s1_d.k = KW'(N - 2);
        else if (in_allzero) s1_d.k = KW'(-(N - 1));
        else                 s1_d.k = regime_k(in_body[BW-1], enc_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_advance) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    // Shifting the terminator out leaves the exponent/fraction bits MSB-aligned.
    assign shamt   = JW'(BW) - s1_q.j;
    assign shifted = s1_q.body << shamt;

    always_comb begin
        res_d      = '0;
        res_d.sign = s1_q.sign;
        res_d.zero = s1_q.allzero & ~s1_q.sign;
        res_d.nar  = s1_q.allzero & s1_q.sign;
        if (!s1_q.allzero) begin
            res_d.k = s1_q.k;
            if (!s1_q.allone) begin
                res_d.exp  = shifted[BW-1 -: ES];
                res_d.frac = shifted[BW-1-ES -: FW];
            end
            res_d.scale = {res_d.k, res_d.exp};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            res_q    <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) res_q <= res_d;
        end
    end

    assign out_valid = s2_valid;
    assign out_sign  = res_q.sign;
    assign out_zero  = res_q.zero;
    assign out_nar   = res_q.nar;
    assign out_k     = res_q.k;
    assign out_exp   = res_q.exp;
    assign out_frac  = res_q.frac;
    assign out_scale = res_q.scale;

`ifdef POSIT_ONEHOT_CHECK_EN
    logic err_q;
    logic bad_in;
    logic oh_any;

    assign oh_any = |in_onehot;
    assign bad_in = (|(in_onehot & (in_onehot - OW'(1))))
                  | (!oh_any & !in_allone & !in_allzero)
                  | (oh_any & (in_allone | in_allzero))
                  | (in_allone & in_allzero);

    always_ff @(posedge clk) begin
        if (rst)                              err_q <= 1'b0;
        else if (in_valid & in_ready & bad_in) err_q <= 1'b1;
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_posit_field_extract.sv
// Randomized and directed bench for posit_field_extract with a posit-semantics
// reference model and an in-order scoreboard.
module tb_posit_field_extract;

    localparam int N  = 8;
    localparam int ES = 1;
    localparam int FW = N - 3 - ES;

    typedef struct {
        int sign, zero, nar, k, exp, frac, scale;
        int acc_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic [N-2:0]      in_body = '0;
    logic [N-3:0]      in_onehot = '0;
    logic              in_allone = 1'b0;
    logic              in_allzero = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_sign, out_zero, out_nar;
    logic signed [3:0] out_k;
    logic [ES-1:0]     out_exp;
    logic [FW-1:0]     out_frac;
    logic signed [4:0] out_scale;
    logic              out_err;

    posit_field_extract dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_body(in_body), .in_onehot(in_onehot),
        .in_allone(in_allone), .in_allzero(in_allzero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_zero(out_zero), .out_nar(out_nar),
        .out_k(out_k), .out_exp(out_exp), .out_frac(out_frac),
        .out_scale(out_scale), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   fires = 0;
    exp_t sb[$];
    exp_t last;
    int   last_lat = -1;
    bit   held = 0;
    int   held_data = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // What the leading-digit detector would present for a given body.
    task automatic detect(input logic [N-2:0] b, output logic [N-3:0] oh,
                          output logic a1, output logic a0);
        oh = '0; a1 = 0; a0 = 0;
        for (int j = N - 3; j >= 0; j--) begin
            if (b[j] != b[N-2]) begin
                oh[j] = 1'b1;
                return;
            end
        end
        a1 = b[N-2];
        a0 = !b[N-2];
    endtask

    function automatic exp_t model(input logic s, input logic [N-2:0] b);
        exp_t e;
        int m, nrem, rem, nf, fb;
        logic lead;
        e = '{default: 0};
        e.sign = s;
        lead = b[N-2];
        m = 1;
        while (m < N - 1 && b[N-2-m] == lead) m++;
        if (m == N - 1) begin
            if (lead) begin
                e.k = N - 2;
                e.scale = e.k * (1 << ES);
            end else begin
                e.zero = !s;
                e.nar  = s;
            end
            return e;
        end
        e.k  = lead ? m - 1 : -m;
        nrem = N - 2 - m;
        rem  = int'(b) & ((1 << nrem) - 1);
        if (nrem >= ES) begin
            e.exp = rem >> (nrem - ES);
            nf    = nrem - ES;
            fb    = rem & ((1 << nf) - 1);
            e.frac = fb << (FW - nf);
        end else begin
            e.exp = rem << (ES - nrem);
        end
        e.scale = e.k * (1 << ES) + e.exp;
        return e;
    endfunction

    function automatic int out_vec();
        return int'({out_sign, out_zero, out_nar, out_k, out_exp, out_frac, out_scale});
    endfunction

    task automatic cycle(input logic v, input logic s, input logic [N-2:0] b,
                         input logic [N-3:0] oh, input logic a1, input logic a0,
                         input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_sign = s; in_body = b; in_onehot = oh;
        in_allone = a1; in_allzero = a0; out_ready = ordy;
        #1;
        if (held) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", out_vec(), held_data);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sign", int'(out_sign), e.sign);
                check("zero", int'(out_zero), e.zero);
                check("nar", int'(out_nar), e.nar);
                check("k", int'(out_k), e.k);
                check("exp", int'(out_exp), e.exp);
                check("frac", int'(out_frac), e.frac);
                check("scale", int'(out_scale), e.scale);
                last = e;
                last_lat = cyc - e.acc_cyc;
            end
            fires++;
        end
        held = out_valid && !out_ready;
        held_data = out_vec();
        acc = v && in_ready;
        if (acc) begin
            e = model(s, b);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic send(input logic v, input logic s, input logic [N-2:0] b,
                        input logic ordy, output logic acc);
        logic [N-3:0] oh;
        logic a1, a0;
        detect(b, oh, a1, a0);
        cycle(v, s, b, oh, a1, a0, ordy, acc);
    endtask

    task automatic send_one(input string tag, input logic s, input logic [N-2:0] b);
        logic acc;
        int f0;
        f0 = fires;
        send(1, s, b, 1, acc);
        check({tag, "_acc"}, int'(acc), 1);
        for (int i = 0; i < 6 && fires == f0; i++) send(0, 0, '0, 1, acc);
        check({tag, "_fire"}, fires - f0, 1);
        check({tag, "_lat"}, last_lat, 2);
    endtask

    initial begin
        logic acc;
        int f0, n_acc;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 0;
        #1;
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_out_valid", int'(out_valid), 0);
        check("post_rst_err", int'(out_err), 0);

        send_one("ex1", 0, 7'b1010110);
        check("ex1_k_const", last.k, 0);
        check("ex1_exp_const", last.exp, 1);
        check("ex1_frac_const", last.frac, 4'b0110);
        check("ex1_scale_const", last.scale, 1);
        send_one("ex2", 0, 7'b0001101);
        check("ex2_k_const", last.k, -3);
        check("ex2_scale_const", last.scale, -5);
        send_one("ex3", 1, 7'b1111110);
        check("ex3_k_const", last.k, 5);
        check("ex3_scale_const", last.scale, 10);
        send_one("allone", 0, 7'b1111111);
        check("allone_scale_const", last.scale, 12);
        send_one("zero", 0, 7'b0000000);
        check("zero_flag_const", last.zero, 1);
        send_one("nar", 1, 7'b0000000);
        check("nar_flag_const", last.nar, 1);

        // backpressure: three inputs against a stalled sink
        f0 = fires;
        n_acc = 0;
        for (int i = 0; i < 2; i++) begin
            send(1, i[0], 7'b0110011 ^ 7'(i), 0, acc);
            n_acc += int'(acc);
        end
        check("bp_two_accepts", n_acc, 2);
        for (int i = 0; i < 3; i++) begin
            send(1, 0, 7'b1100101, 0, acc);
            check("bp_in_ready_low", int'(acc), 0);
        end
        send(1, 0, 7'b1100101, 1, acc);
        check("bp_third_accept", int'(acc), 1);
        for (int i = 0; i < 8 && sb.size() != 0; i++) send(0, 0, '0, 1, acc);
        check("bp_fire_count", fires - f0, 3);
        check("bp_sb_empty", sb.size(), 0);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom_range(0, 3) != 0), 1'($urandom), 7'($urandom),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) send(0, 0, '0, 1, acc);
        check("drain_empty", sb.size(), 0);
        check("random_err_clear", int'(out_err), 0);

        // fill both stages, then reset mid-flight
`ifdef POSIT_ONEHOT_CHECK_EN
        cycle(1, 0, 7'b1111100, 6'b000011, 0, 0, 0, acc);
`else
        send(1, 0, 7'b1111100, 0, acc);
`endif
        check("mid_acc1", int'(acc), 1);
        send(1, 1, 7'b0100110, 0, acc);
        check("mid_acc2", int'(acc), 1);
        send(0, 0, '0, 0, acc);
        check("mid_full_in_ready", int'(in_ready), 0);
        check("mid_full_out_valid", int'(out_valid), 1);
`ifdef POSIT_ONEHOT_CHECK_EN
        check("err_sticky", int'(out_err), 1);
`else
        check("err_tied_low", int'(out_err), 0);
`endif
        @(negedge clk);
        rst = 1;
        in_valid = 1;
        #1;
        check("in_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        #1;
        check("after_rst_out_valid", int'(out_valid), 0);
        check("after_rst_in_ready", int'(in_ready), 1);
        check("after_rst_err", int'(out_err), 0);
        sb.delete();
        held = 0;

        send_one("post_rst", 0, 7'b0001101);
        check("post_rst_k_const", last.k, -3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
